// File: rtl/ad_nios_interval_timer_ctrl_pkg.sv
// Shared constants for the Nios interval timer: register map, bit positions
// within STATUS/CONTROL, and the controller state encoding.
package ad_nios_timer_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_PRESCALE = 3'd3;
    localparam logic [2:0] ADDR_SNAPSHOT = 3'd4;

    localparam int STATUS_TO  = 0;
    localparam int STATUS_RUN = 1;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ad_nios_interval_timer_ctrl_if.sv
// Nios peripheral slave bus: register select, strobes, write data and the
// registered read data returned by the peripheral.
interface ad_nios_interval_timer_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [2:0]       address;
    logic             chipselect;
    logic             write;
    logic [WIDTH-1:0] writedata;
    logic             read;
    logic [WIDTH-1:0] readdata;

    modport master (
        output address, chipselect, write, writedata, read,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, writedata, read,
        output readdata
    );
endinterface

// File: rtl/ad_nios_interval_timer_ctrl_prescaler.sv
// Clock divider for the timer: emits one tick every (div+1) enabled clocks.
// A clear restarts the division so a freshly started interval is exact.
module ad_nios_timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    assign tick = en && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ad_nios_interval_timer_ctrl.sv
// Interval timer controller: bus register file, IDLE/RUN sequencer and the
// down-counter with reload, timeout flag, expiry pulse and interrupt.
module ad_nios_interval_timer_ctrl
    import ad_nios_timer_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    ad_nios_interval_timer_ctrl_if.slave bus,
    output logic                         irq,
    output logic                         timeout_pulse
);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      period_q, count_q, snapshot_q, readdata_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  ito_q, cont_q, to_q, pulse_q;

    logic             wr_en, rd_en, ctrl_wr, start_req, stop_req;
    logic             running, tick, expire, load_count, dec_count;
    logic [WIDTH-1:0] rd_mux;

    assign wr_en     = bus.chipselect && bus.write;
    assign rd_en     = bus.chipselect && bus.read;
    assign ctrl_wr   = wr_en && (bus.address == ADDR_CONTROL);
    assign start_req = ctrl_wr && bus.writedata[CTRL_START];
    assign stop_req  = ctrl_wr && bus.writedata[CTRL_STOP];
    assign running   = (state_q == ST_RUN);

    ad_nios_timer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (start_req && !stop_req),
        .en    (running),
        .div   (prescale_q),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // STOP outranks both START and a coincident expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_req && !stop_req) state_d = ST_RUN;
            ST_RUN: begin
                if (stop_req)                state_d = ST_IDLE;
                else if (start_req)          state_d = ST_RUN;
                else if (expire && !cont_q)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A restart swallows any expiry landing on the same edge.
    always_comb begin
        expire     = running && tick && (count_q == '0) && !stop_req && !start_req;
        dec_count  = running && tick && (count_q != '0) && !stop_req && !start_req;
        load_count = (start_req && !stop_req) || expire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_count) begin
            count_q <= period_q;
        end else if (dec_count) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q   <= '0;
            prescale_q <= '0;
            snapshot_q <= '0;
            ito_q      <= 1'b0;
            cont_q     <= 1'b0;
            to_q       <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            pulse_q <= expire;
            if (expire) begin
                to_q <= 1'b1;
            end else if (wr_en && bus.address == ADDR_STATUS) begin
                to_q <= 1'b0;
            end
            if (ctrl_wr) begin
                ito_q  <= bus.writedata[CTRL_ITO];
                cont_q <= bus.writedata[CTRL_CONT];
            end
            if (wr_en && bus.address == ADDR_PERIOD)   period_q   <= bus.writedata;
            if (wr_en && bus.address == ADDR_PRESCALE) prescale_q <= bus.writedata[PRESCALE_W-1:0];
            if (wr_en && bus.address == ADDR_SNAPSHOT) snapshot_q <= count_q;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_STATUS: begin
                rd_mux[STATUS_TO]  = to_q;
                rd_mux[STATUS_RUN] = running;
            end
            ADDR_CONTROL: begin
                rd_mux[CTRL_ITO]  = ito_q;
                rd_mux[CTRL_CONT] = cont_q;
            end
            ADDR_PERIOD:   rd_mux = period_q;
            ADDR_PRESCALE: rd_mux = WIDTH'(prescale_q);
            ADDR_SNAPSHOT: rd_mux = snapshot_q;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            readdata_q <= rd_mux;
        end
    end

    assign bus.readdata  = readdata_q;
    assign irq           = to_q && ito_q;
    assign timeout_pulse = pulse_q;

endmodule
